// File: rtl/time_set_if.sv
// Bus between a time-setting byte source and the time_set_rx receiver.
// master drives the byte strobe; slave returns the frame status and the loaded time.
interface time_set_if;
  logic [7:0] ipins;
  logic       istb;
  logic       busy;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output ipins, istb,
    input  busy, load, load_hours, load_minutes, load_seconds, err, err_code
  );

  modport slave (
    input  ipins, istb,
    output busy, load, load_hours, load_minutes, load_seconds, err, err_code
  );
endinterface

// File: rtl/time_set_rx.sv
// Receives SYNC,H,M,S,CHK byte frames and loads a validated hh:mm:ss time.
// Optional inter-byte timeout enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 200
) (
  input  logic      clk,
  input  logic      rst,
  time_set_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GET_H, GET_M, GET_S, GET_C} state_t;

  state_t     state, state_nxt;
  logic [4:0] hours_p0;
  logic [5:0] minutes_p0, seconds_p0;
  logic       cap_h, cap_m, cap_s;
  logic       do_load, do_abort;
  logic [1:0] abort_code;
  logic       expired;
  logic [7:0] csum;

  logic       load_p1, err_p1;
  logic [1:0] err_code_p1;
  logic [4:0] hours_p1;
  logic [5:0] minutes_p1, seconds_p1;

  assign csum = {3'b000, hours_p0} ^ {2'b00, minutes_p0} ^ {2'b00, seconds_p0};

`ifdef TIME_SET_TIMEOUT_EN
  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr;

  // Counts idle cycles since the last accepted byte; a strobe on the expiry cycle wins.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || bus.istb || expired) tmr <= '0;
    else                                             tmr <= tmr + 1'b1;
  end

  assign expired = (state != IDLE) && !bus.istb && (tmr == TMR_LAST);
`else
  // Without the timer nothing expires; a frame waits for its next byte indefinitely.
  assign expired = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_nxt  = state;
    cap_h      = 1'b0;
    cap_m      = 1'b0;
    cap_s      = 1'b0;
    do_load    = 1'b0;
    do_abort   = 1'b0;
    abort_code = 2'b00;
    if (bus.istb) begin
      case (state)
        IDLE: if (bus.ipins == SYNC_BYTE) state_nxt = GET_H;
        GET_H: begin
          if (bus.ipins <= 8'd23) begin
            cap_h     = 1'b1;
            state_nxt = GET_M;
          end else begin
            do_abort   = 1'b1;
            abort_code = 2'b01;
            state_nxt  = IDLE;
          end
        end
        GET_M: begin
          if (bus.ipins <= 8'd59) begin
            cap_m     = 1'b1;
            state_nxt = GET_S;
          end else begin
            do_abort   = 1'b1;
            abort_code = 2'b01;
            state_nxt  = IDLE;
          end
        end
        GET_S: begin
          if (bus.ipins <= 8'd59) begin
            cap_s     = 1'b1;
            state_nxt = GET_C;
          end else begin
            do_abort   = 1'b1;
            abort_code = 2'b01;
            state_nxt  = IDLE;
          end
        end
        GET_C: begin
          if (bus.ipins == csum) begin
            do_load = 1'b1;
          end else begin
            do_abort   = 1'b1;
            abort_code = 2'b10;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (expired) begin
      do_abort   = 1'b1;
      abort_code = 2'b11;
      state_nxt  = IDLE;
    end
  end

  // Stage p0: partial frame captures, kept apart from the loaded time.
  always_ff @(posedge clk) begin
    if (cap_h) hours_p0   <= bus.ipins[4:0];
    if (cap_m) minutes_p0 <= bus.ipins[5:0];
    if (cap_s) seconds_p0 <= bus.ipins[5:0];
  end

  // Stage p1: FSM state and registered frame results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      load_p1     <= 1'b0;
      err_p1      <= 1'b0;
      err_code_p1 <= 2'b00;
      hours_p1    <= '0;
      minutes_p1  <= '0;
      seconds_p1  <= '0;
    end else begin
      state   <= state_nxt;
      load_p1 <= do_load;
      err_p1  <= do_abort;
      if (do_abort) err_code_p1 <= abort_code;
      if (do_load) begin
        hours_p1   <= hours_p0;
        minutes_p1 <= minutes_p0;
        seconds_p1 <= seconds_p0;
      end
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.load         = load_p1;
  assign bus.err          = err_p1;
  assign bus.err_code     = err_code_p1;
  assign bus.load_hours   = hours_p1;
  assign bus.load_minutes = minutes_p1;
  assign bus.load_seconds = seconds_p1;

endmodule

// File: tb/tb_time_set_rx.sv
// Scoreboard bench for time_set_rx: directed frames push expected load/err events,
// a negedge monitor pops and compares them whenever load or err is presented.
module tb_time_set_rx;

  logic clk = 1'b0;
  logic rst;

  time_set_if bus ();

  time_set_rx #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_load;
    logic [1:0] code;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] mh = '0;
  logic [5:0] mm = '0, ms = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    exp_t e;
    mh = h; mm = m; ms = s;
    e.is_load = 1'b1; e.code = 2'b00; e.h = h; e.m = m; e.s = s;
    sbq.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_load = 1'b0; e.code = code; e.h = mh; e.m = mm; e.s = ms;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.ipins = b;
    bus.istb  = 1'b1;
    @(negedge clk);
    bus.istb  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                       input logic [7:0] c, input int gap);
    send(8'hA5, gap);
    check("busy_after_sync", bus.busy, 1);
    send(h, gap);
    send(m, gap);
    send(s, gap);
    send(c, gap);
  endtask

  // Monitor: every load/err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (bus.load || bus.err)) begin
      check("load_err_exclusive", bus.load & bus.err, 0);
      if (sbq.size() == 0) begin
        check("unexpected_output", {bus.load, bus.err}, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("event_kind_load", bus.load, mon_e.is_load);
        check("busy_low_on_event", bus.busy, 0);
        if (bus.err) check("err_code", bus.err_code, mon_e.code);
        check("load_hours", bus.load_hours, mon_e.h);
        check("load_minutes", bus.load_minutes, mon_e.m);
        check("load_seconds", bus.load_seconds, mon_e.s);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus.istb  = 1'b0;
    bus.ipins = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_load", bus.load, 0);
    check("rst_err", bus.err, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_hours", bus.load_hours, 0);
    check("rst_minutes", bus.load_minutes, 0);
    check("rst_seconds", bus.load_seconds, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 12:30:45, checksum 0x3F, one strobe every 3 cycles
    push_load(5'd12, 6'd30, 6'd45);
    frame(8'h0C, 8'h1E, 8'h2D, 8'h3F, 1);
    repeat (3) @(negedge clk);

    // hours 24 out of range
    push_err(2'b01);
    send(8'hA5, 1);
    send(8'h18, 1);
    repeat (2) @(negedge clk);
    check("idle_after_range", bus.busy, 0);

    // bad checksum, then the good one for 23:59:59
    push_err(2'b10);
    frame(8'h17, 8'h3B, 8'h3B, 8'h00, 1);
    push_load(5'd23, 6'd59, 6'd59);
    frame(8'h17, 8'h3B, 8'h3B, 8'h17, 1);
    repeat (2) @(negedge clk);
    check("err_code_holds", bus.err_code, 2'b10);

    // 0x98 must not pass as a truncated 24
    push_err(2'b01);
    send(8'hA5, 1);
    send(8'h98, 1);
    // minutes 60 out of range
    push_err(2'b01);
    send(8'hA5, 1);
    send(8'h05, 1);
    send(8'h3C, 1);
    // sync byte mid-frame is data, not a restart
    push_err(2'b01);
    send(8'hA5, 1);
    send(8'hA5, 1);
    repeat (2) @(negedge clk);

    // leading junk ignored, back-to-back valid frame 01:02:03
    send(8'h00, 0);
    send(8'hFF, 0);
    check("junk_not_busy", bus.busy, 0);
    push_load(5'd1, 6'd2, 6'd3);
    frame(8'h01, 8'h02, 8'h03, 8'h00, 0);
    repeat (2) @(negedge clk);

    // reset mid-frame discards it and clears the loaded time
    send(8'hA5, 1);
    send(8'h01, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mh = '0; mm = '0; ms = '0;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_hours", bus.load_hours, 0);
    check("rst_mid_err_code", bus.err_code, 0);
    send(8'h02, 1);
    send(8'h03, 1);
    send(8'h00, 1);
    push_load(5'd5, 6'd6, 6'd7);
    frame(8'h05, 8'h06, 8'h07, 8'h04, 1);
    repeat (2) @(negedge clk);

    // hours byte arrives exactly 200 cycles after the sync strobe
    push_load(5'd10, 6'd11, 6'd12);
    @(negedge clk);
    bus.ipins = 8'hA5;
    bus.istb  = 1'b1;
    @(negedge clk);
    bus.istb  = 1'b0;
    repeat (199) @(negedge clk);
    bus.ipins = 8'h0A;
    bus.istb  = 1'b1;
    @(negedge clk);
    bus.istb  = 1'b0;
    check("busy_after_late_strobe", bus.busy, 1);
    send(8'h0B, 1);
    send(8'h0C, 1);
    send(8'h0D, 1);
    repeat (2) @(negedge clk);

`ifdef TIME_SET_TIMEOUT_EN
    begin
      int lat;
      lat = -1;
      push_err(2'b11);
      @(negedge clk);
      bus.ipins = 8'hA5;
      bus.istb  = 1'b1;
      @(negedge clk);
      bus.istb  = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (bus.err) begin
          lat = i;
          break;
        end
      end
      check("timeout_latency", lat, 199);
      check("timeout_busy", bus.busy, 0);
      check("timeout_code", bus.err_code, 2'b11);
    end
`else
    // without the timer a frame waits indefinitely
    push_load(5'd2, 6'd4, 6'd8);
    send(8'hA5, 300);
    check("no_timeout_busy", bus.busy, 1);
    send(8'h02, 1);
    send(8'h04, 1);
    send(8'h08, 1);
    send(8'h0E, 1);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
